// File: rtl/branch_predictor_ctrl.sv
// Branch predictor: direct-mapped BTB of 2-bit saturating counters with
// zero-latency fetch lookup, EX-stage update, mispredict flag and perf counters.
module branch_predictor_ctrl #(
    parameter int DATA_W  = 16,
    parameter int INDEX_W = 4,
    parameter int TAG_W   = DATA_W - INDEX_W - 2
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [DATA_W-1:0] fetch_pc,
    output logic              predict_taken,
    output logic [DATA_W-1:0] predict_pc,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic              ex_taken,
    input  logic [DATA_W-1:0] ex_target,
    input  logic              ex_predicted,
    output logic              mispredict,
    output logic [15:0]       branch_count,
    output logic [15:0]       mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_W;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [DATA_W-1:0] target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [INDEX_W-1:0] f_idx;
    logic [INDEX_W-1:0] e_idx;
    logic [TAG_W-1:0]   f_tag;
    logic [TAG_W-1:0]   e_tag;
    logic               f_hit;
    logic               e_hit;
    logic [DATA_W-1:0]  seq_pc;
    logic               unused_pc_bits;

    assign f_idx = fetch_pc[INDEX_W+1:2];
    assign f_tag = fetch_pc[DATA_W-1:INDEX_W+2];
    assign e_idx = ex_pc[INDEX_W+1:2];
    assign e_tag = ex_pc[DATA_W-1:INDEX_W+2];

    // Low PC bits never select an entry; the fetch side still uses them in +4.
    assign unused_pc_bits = ^ex_pc[1:0];

    assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign e_hit  = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign seq_pc = fetch_pc + DATA_W'(4);

    // Lookup reads the registered table, so a same-cycle update is not bypassed.
    assign predict_taken = f_hit && ctr_q[f_idx][1];
    assign predict_pc    = predict_taken ? target_q[f_idx] : seq_pc;

    assign mispredict = !arst && ex_valid && (ex_taken != ex_predicted);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (ex_valid) begin
            if (e_hit) begin
                if (ex_taken) begin
                    if (ctr_q[e_idx] != 2'b11) begin
                        ctr_q[e_idx] <= ctr_q[e_idx] + 2'b01;
                    end
                    target_q[e_idx] <= ex_target;
                end else if (ctr_q[e_idx] != 2'b00) begin
                    ctr_q[e_idx] <= ctr_q[e_idx] - 2'b01;
                end
            end else if (ex_taken) begin
                // Allocate, evicting any aliased entry at this index.
                valid_q[e_idx]  <= 1'b1;
                tag_q[e_idx]    <= e_tag;
                target_q[e_idx] <= ex_target;
                ctr_q[e_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (ex_valid) begin
                branch_count <= branch_count + 16'd1;
            end
            if (mispredict) begin
                mispredict_count <= mispredict_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Directed table-driven bench for branch_predictor_ctrl plus hand-written
// reset-mid-update and wrap-around sequences.
module tb_branch_predictor_ctrl;

    logic        clk;
    logic        arst;
    logic [15:0] fetch_pc;
    logic        predict_taken;
    logic [15:0] predict_pc;
    logic        ex_valid;
    logic [15:0] ex_pc;
    logic        ex_taken;
    logic [15:0] ex_target;
    logic        ex_predicted;
    logic        mispredict;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    int checks;
    int failures;

    branch_predictor_ctrl dut (
        .clk             (clk),
        .arst            (arst),
        .fetch_pc        (fetch_pc),
        .predict_taken   (predict_taken),
        .predict_pc      (predict_pc),
        .ex_valid        (ex_valid),
        .ex_pc           (ex_pc),
        .ex_taken        (ex_taken),
        .ex_target       (ex_target),
        .ex_predicted    (ex_predicted),
        .mispredict      (mispredict),
        .branch_count    (branch_count),
        .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] fpc;
        logic        ev;
        logic [15:0] epc;
        logic        et;
        logic [15:0] etgt;
        logic        epred;
        logic        x_taken;
        logic [15:0] x_pc;
        logic        x_mis;
        logic [15:0] x_bc;
        logic [15:0] x_mc;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic x_taken,
                           input logic [15:0] x_pc, input logic x_mis,
                           input logic [15:0] x_bc, input logic [15:0] x_mc);
        chk({tag, ".predict_taken"}, 32'(predict_taken), 32'(x_taken));
        chk({tag, ".predict_pc"}, 32'(predict_pc), 32'(x_pc));
        chk({tag, ".mispredict"}, 32'(mispredict), 32'(x_mis));
        chk({tag, ".branch_count"}, 32'(branch_count), 32'(x_bc));
        chk({tag, ".mispredict_count"}, 32'(mispredict_count), 32'(x_mc));
    endtask

    function automatic vec_t mk(
        logic [15:0] fpc, logic ev, logic [15:0] epc, logic et,
        logic [15:0] etgt, logic epred, logic x_taken, logic [15:0] x_pc,
        logic x_mis, logic [15:0] x_bc, logic [15:0] x_mc);
        vec_t v;
        v.fpc = fpc; v.ev = ev; v.epc = epc; v.et = et; v.etgt = etgt;
        v.epred = epred; v.x_taken = x_taken; v.x_pc = x_pc;
        v.x_mis = x_mis; v.x_bc = x_bc; v.x_mc = x_mc;
        return v;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;

        //             fpc     ev epc     et tgt     pr  xt xpc     xm bc  mc
        vecs[0]  = mk(16'h0040,0,16'h0000,0,16'h0000,0, 0,16'h0044,0, 0, 0);
        vecs[1]  = mk(16'h0040,1,16'h0040,1,16'h0020,0, 0,16'h0044,1, 0, 0);
        vecs[2]  = mk(16'h0040,0,16'h0000,0,16'h0000,0, 1,16'h0020,0, 1, 1);
        vecs[3]  = mk(16'h0040,1,16'h0040,1,16'h0020,1, 1,16'h0020,0, 1, 1);
        vecs[4]  = mk(16'h0040,1,16'h0040,1,16'h0020,1, 1,16'h0020,0, 2, 1);
        vecs[5]  = mk(16'h0040,1,16'h0040,1,16'h0020,1, 1,16'h0020,0, 3, 1);
        vecs[6]  = mk(16'h0040,1,16'h0040,1,16'h0020,1, 1,16'h0020,0, 4, 1);
        vecs[7]  = mk(16'h0040,1,16'h0040,0,16'h0000,1, 1,16'h0020,1, 5, 1);
        vecs[8]  = mk(16'h0040,0,16'h0000,0,16'h0000,0, 1,16'h0020,0, 6, 2);
        // same-cycle lookup sees old ctr=2 while update drives it to 1
        vecs[9]  = mk(16'h0040,1,16'h0040,0,16'h0000,1, 1,16'h0020,1, 6, 2);
        vecs[10] = mk(16'h0040,0,16'h0000,0,16'h0000,0, 0,16'h0044,0, 7, 3);
        vecs[11] = mk(16'h0040,1,16'h0040,1,16'h0020,0, 0,16'h0044,1, 7, 3);
        vecs[12] = mk(16'h0040,0,16'h0000,0,16'h0000,0, 1,16'h0020,0, 8, 4);
        // alias at index 0 evicts 0x0040
        vecs[13] = mk(16'h0080,1,16'h0080,1,16'h0100,0, 0,16'h0084,1, 8, 4);
        vecs[14] = mk(16'h0040,0,16'h0000,0,16'h0000,0, 0,16'h0044,0, 9, 5);
        vecs[15] = mk(16'h0080,0,16'h0000,0,16'h0000,0, 1,16'h0100,0, 9, 5);
        vecs[16] = mk(16'h0080,1,16'h0080,0,16'h0000,1, 1,16'h0100,1, 9, 5);
        vecs[17] = mk(16'h0080,0,16'h0000,0,16'h0000,0, 0,16'h0084,0,10, 6);
        vecs[18] = mk(16'h0044,1,16'h0044,0,16'h0000,0, 0,16'h0048,0,10, 6);
        vecs[19] = mk(16'h0083,0,16'h0080,1,16'h0300,0, 0,16'h0087,0,11, 6);
        vecs[20] = mk(16'h0044,0,16'h0000,0,16'h0000,0, 0,16'h0048,0,11, 6);

        arst = 1'b1;
        fetch_pc = 16'h0040;
        ex_valid = 1'b0;
        ex_pc = '0;
        ex_taken = 1'b0;
        ex_target = '0;
        ex_predicted = 1'b0;
        #1;
        chk_all("reset", 1'b0, 16'h0044, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            fetch_pc     = vecs[i].fpc;
            ex_valid     = vecs[i].ev;
            ex_pc        = vecs[i].epc;
            ex_taken     = vecs[i].et;
            ex_target    = vecs[i].etgt;
            ex_predicted = vecs[i].epred;
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].x_taken, vecs[i].x_pc,
                    vecs[i].x_mis, vecs[i].x_bc, vecs[i].x_mc);
        end

        // Re-establish a taken entry at 0x0040, then reset during an update.
        @(negedge clk);
        fetch_pc = 16'h0040;
        ex_valid = 1'b1;
        ex_pc = 16'h0040;
        ex_taken = 1'b1;
        ex_target = 16'h0200;
        ex_predicted = 1'b0;
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        chk_all("pre_rst", 1'b1, 16'h0200, 1'b0, 16'd12, 16'd7);

        @(negedge clk);
        fetch_pc = 16'h0080;
        ex_valid = 1'b1;
        ex_pc = 16'h0080;
        ex_taken = 1'b1;
        ex_target = 16'h0400;
        ex_predicted = 1'b0;
        #1;
        arst = 1'b1;
        #1;
        chk_all("mid_rst", 1'b0, 16'h0084, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        arst = 1'b0;
        #1;
        chk_all("rst_discard", 1'b0, 16'h0084, 1'b0, 16'd0, 16'd0);
        fetch_pc = 16'h0040;
        #1;
        chk_all("rst_clear", 1'b0, 16'h0044, 1'b0, 16'd0, 16'd0);

        @(negedge clk);
        fetch_pc = 16'hFFFC;
        #1;
        chk_all("wrap", 1'b0, 16'h0000, 1'b0, 16'd0, 16'd0);

        // Counters restart from zero after reset.
        @(negedge clk);
        ex_valid = 1'b1;
        ex_pc = 16'hFFFC;
        ex_taken = 1'b1;
        ex_target = 16'h1234;
        ex_predicted = 1'b0;
        #1;
        chk_all("wrap_upd", 1'b0, 16'h0000, 1'b1, 16'd0, 16'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        chk_all("wrap_hit", 1'b1, 16'h1234, 1'b0, 16'd1, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor_ctrl.md
Name: branch_predictor_ctrl

Overview:
- Dynamic branch predictor and controller for the fetch/execute branch path.
- Fetch stage: looks up the fetch PC in a direct-mapped branch target buffer (BTB) of 2-bit saturating counters and supplies a predicted direction and next PC.
- Execute stage: takes the resolved outcome from the branch unit (should-have-taken flag and target). It updates the table, raises a mispredict signal, and keeps performance counters.

Parameters:
- DATA_W, 16: PC/target width in bits.
- INDEX_W, 4: BTB index width; 2**INDEX_W entries, indexed by PC[INDEX_W+1:2].
- TAG_W, DATA_W-INDEX_W-2: tag width; tag = PC[DATA_W-1:INDEX_W+2].

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- arst  in  1  asynchronous active-high reset.
- fetch_pc  in  DATA_W  PC currently being fetched.
- predict_taken  out  1  predicted direction for fetch_pc.
- predict_pc  out  DATA_W  predicted next PC.
- ex_valid  in  1  a conditional branch is resolving in EX this cycle.
- ex_pc  in  DATA_W  PC of the resolving branch.
- ex_taken  in  1  actual direction (should-have-taken) from the branch unit.
- ex_target  in  DATA_W  taken-target PC from the branch unit.
- ex_predicted  in  1  predict_taken value carried down the pipeline with this branch.
- mispredict  out  1  EX-stage direction mismatch; drives pipeline flush and branch_pc select.
- branch_count  out  16  resolved branches since reset.
- mispredict_count  out  16  mispredictions since reset.

Behaviour:
- Storage per entry: valid (1), tag (TAG_W), target (DATA_W), ctr (2).
- Reset (arst=1, asynchronous): all valid=0, all ctr=2'b01 (weakly not-taken), tag and target=0, both counters=0.
- Reset outputs: predict_taken=0, predict_pc=fetch_pc+4, mispredict=0.
- Reset asserted mid-update: the update is discarded.

Lookup (combinational, zero latency):
- hit = valid[idx] && tag[idx]==fetch_pc tag.
- predict_taken = hit && ctr[idx][1].
- predict_pc = predict_taken ? target[idx] : fetch_pc + 4, modulo 2**DATA_W (wraps at top of address space).

Mispredict (combinational):
- mispredict = ex_valid && (ex_taken != ex_predicted).
- Zero whenever ex_valid=0.

Update (on rising clk when ex_valid=1, entry e indexed by ex_pc):
- Hit in e, ex_taken=1: ctr = min(ctr+1, 3); target = ex_target.
- Hit in e, ex_taken=0: ctr = max(ctr-1, 0); target unchanged.
- Miss, ex_taken=1: allocate or replace. valid=1, tag=ex_pc tag, target=ex_target, ctr=2'b10 (weakly taken).
- Miss, ex_taken=0: no table change.
- ex_valid=0: no table change.

Counters:
- branch_count += 1 on every cycle with ex_valid.
- mispredict_count += 1 on every cycle with mispredict.
- Both wrap from 16'hFFFF to 0.

Simultaneous events:
- Lookup and update to the same index in one cycle: lookup returns the pre-update (old) entry. The new value is visible from the next cycle. No write-through bypass.
- Aliasing: a different tag at the same index is a miss. A taken branch evicts the resident entry.

Width rules:
- All PC arithmetic is unsigned DATA_W, truncated.
- fetch_pc[1:0] and ex_pc[1:0] are ignored.

Test Plan:
1. Reset, then fetch_pc=16'h0040 -> predict_taken=0, predict_pc=16'h0044; counters=0.
2. ex_valid=1, ex_pc=16'h0040, ex_taken=1, ex_target=16'h0020, ex_predicted=0 -> mispredict=1 that cycle; next cycle fetch_pc=16'h0040 gives predict_taken=1, predict_pc=16'h0020; branch_count=1, mispredict_count=1.
3. Counter saturation: four further taken updates at 16'h0040, then one not-taken -> ctr goes 2,3,3,3,3,2; prediction stays taken. A second not-taken -> ctr=1, predict_taken=0, predict_pc=16'h0044.
4. Alias (INDEX_W=4): entry at 16'h0040 valid/taken; taken update at 16'h0080 (same index 0, different tag) with target 16'h0100 -> 16'h0040 now misses (predict_pc=16'h0044); 16'h0080 predicts 16'h0100 with ctr=2.
5. Same-cycle lookup and update on index of 16'h0040 (not-taken, ctr 2->1) -> that cycle predict_taken=1 (old); next cycle predict_taken=0.
6. Assert arst mid-run with ex_valid=1 -> all outputs return to reset values immediately; after release, 16'hFFFC with no history predicts 16'h0000 (wrap); counters restart at 0.
